// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and default widths for the data-memory arbiter.
//   port_id_t : identifies the requester (CPU controller or host/debug loader)
//   rd_tag_t  : one slot of the read-latency pipeline {valid, port}
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

   localparam int DEF_AW = 8;
   localparam int DEF_DW = 16;

   typedef enum logic {
      PORT_CPU  = 1'b0,
      PORT_HOST = 1'b1
   } port_id_t;

   typedef struct packed {
      logic     valid;
      port_id_t port;
   } rd_tag_t;

   localparam rd_tag_t RD_TAG_IDLE = '{valid: 1'b0, port: PORT_CPU};

endpackage

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// -----------------------------------------------------------------------------
// rd_tag_pipe
// DEPTH-deep shift register of read tags. Each cycle the arbiter pushes one
// tag; the tag leaving the last stage lines up with the memory read data.
// Ports:
//   clk       rising-edge clock
//   flush     synchronous clear of every stage (tied to the arbiter reset)
//   in_valid  tag pushed this cycle marks a granted read
//   in_port   requester of that read (0 = CPU, 1 = host)
//   out_valid tag at the pipeline output is a read
//   out_port  requester of the read at the pipeline output
// -----------------------------------------------------------------------------
module rd_tag_pipe
   import dmem_arb_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic flush,
   input  logic in_valid,
   input  logic in_port,
   output logic out_valid,
   output logic out_port
);

   rd_tag_t pipe_q [DEPTH];
   rd_tag_t pipe_d [DEPTH];

   // NOTE: every variable driven here gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         pipe_d[i] = RD_TAG_IDLE;
      end
      pipe_d[0] = '{valid: in_valid, port: port_id_t'(in_port)};
      for (int i = 1; i < DEPTH; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every stage
   // samples the value its neighbour held before this edge.
   // The tags are cleared on reset (unlike a data RAM) because a stale valid
   // tag would raise RValid for a read the requester never sees completed.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (flush) begin
            pipe_q[i] <= RD_TAG_IDLE;
         end else begin
            pipe_q[i] <= pipe_d[i];
         end
      end
   end

   assign out_valid = pipe_q[DEPTH-1].valid;
   assign out_port  = pipe_q[DEPTH-1].port;

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port synchronous data RAM between the CPU controller
// (port 0) and the host/debug loader (port 1). One access per cycle, granted
// combinationally. The CPU has fixed priority; a host that has lost MAX_WAIT
// consecutive cycles is granted next. Granted reads are tagged and the tag
// travels RD_LAT cycles so the read data is flagged for the right requester.
// Ports:
//   Clk, Rst            clock; synchronous active-high reset
//   ReqN/WrN/AddrN/WDataN  request, direction, address, write data per port
//   GntN                access accepted this cycle
//   RValidN             RData carries the read issued by port N
//   RData               read data (pass-through of Mem_RData)
//   Mem_En/Mem_Wr/Mem_Addr/Mem_WData  RAM command (all zero when idle)
//   Mem_RData           RAM read data, RD_LAT cycles after the address
// -----------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW       = DEF_AW,
   parameter int DW       = DEF_DW,
   parameter int RD_LAT   = 1,
   parameter int MAX_WAIT = 4
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          Req0,
   input  logic          Req1,
   input  logic          Wr0,
   input  logic          Wr1,
   input  logic [AW-1:0] Addr0,
   input  logic [AW-1:0] Addr1,
   input  logic [DW-1:0] WData0,
   input  logic [DW-1:0] WData1,
   output logic          Gnt0,
   output logic          Gnt1,
   output logic          RValid0,
   output logic          RValid1,
   output logic [DW-1:0] RData,
   output logic          Mem_En,
   output logic          Mem_Wr,
   output logic [AW-1:0] Mem_Addr,
   output logic [DW-1:0] Mem_WData,
   input  logic [DW-1:0] Mem_RData
);

   localparam int             WCW        = $clog2(MAX_WAIT + 1);
   localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
   logic           gnt0, gnt1;
   logic           tag_valid, tag_port;

   // Winner selection. Reset masks every grant so nothing reaches the RAM.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!Rst) begin
         if (Req0 && Req1) begin
            if (wait_cnt_q == WAIT_LIMIT) begin
               gnt1 = 1'b1;
            end else begin
               gnt0 = 1'b1;
            end
         end else if (Req0) begin
            gnt0 = 1'b1;
         end else if (Req1) begin
            gnt1 = 1'b1;
         end
      end
   end

   // RAM command mux; an idle bus is driven to all zeros.
   always_comb begin
      Mem_En    = 1'b0;
      Mem_Wr    = 1'b0;
      Mem_Addr  = '0;
      Mem_WData = '0;
      if (gnt0) begin
         Mem_En    = 1'b1;
         Mem_Wr    = Wr0;
         Mem_Addr  = Addr0;
         Mem_WData = WData0;
      end else if (gnt1) begin
         Mem_En    = 1'b1;
         Mem_Wr    = Wr1;
         Mem_Addr  = Addr1;
         Mem_WData = WData1;
      end
   end

   // Consecutive host losses. Any host grant or a withdrawn host request
   // starts the count again; the count saturates at the forcing threshold.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (gnt1 || !Req1) begin
         wait_cnt_d = '0;
      end else if (gnt0 && (wait_cnt_q != WAIT_LIMIT)) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

   rd_tag_pipe #(
      .DEPTH (RD_LAT)
   ) u_rd_tag_pipe (
      .clk       (Clk),
      .flush     (Rst),
      .in_valid  (Mem_En && !Mem_Wr),
      .in_port   (gnt1),
      .out_valid (tag_valid),
      .out_port  (tag_port)
   );

   assign Gnt0  = gnt0;
   assign Gnt1  = gnt1;
   assign RData = Mem_RData;

   // With RD_LAT=1 a read issued just before reset is at the pipeline output
   // during the reset cycle itself; masking with Rst keeps it from reporting.
   assign RValid0 = !Rst && tag_valid && (tag_port == PORT_CPU);
   assign RValid1 = !Rst && tag_valid && (tag_port == PORT_HOST);

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-port 256x16 synchronous data memory between the CPU controller (port 0) and the host/debug loader (port 1). It issues at most one memory access per cycle and gives the CPU fixed priority, with a starvation counter that forces a host grant after MAX_WAIT consecutive losses. It tracks in-flight reads through a latency pipeline and returns read data with a valid pulse to the requester that issued it. It sits between the controller's D_Addr/D_Wr outputs, the loader, and the data RAM.

## Interface
- AW, 8, memory address width
- DW, 16, memory data width
- RD_LAT, 1, memory read latency in cycles (legal 1..3)
- MAX_WAIT, 4, consecutive host losses before the host is forced a grant (legal ≥1)

- Clk  in  1  single clock, all state updates on rising edge
- Rst  in  1  reset, synchronous, active-high
- Req0, Req1  in  1  access request, held until the matching Gnt
- Wr0, Wr1  in  1  1 = write, 0 = read
- Addr0, Addr1  in  AW  access address
- WData0, WData1  in  DW  write data
- Gnt0, Gnt1  out  1  access accepted this cycle (combinational)
- RValid0, RValid1  out  1  RData valid for that port's read
- RData  out  DW  read data, shared; equals Mem_RData
- Mem_En  out  1  memory access this cycle
- Mem_Wr  out  1  memory write strobe
- Mem_Addr  out  AW  memory address
- Mem_WData  out  DW  memory write data
- Mem_RData  in  DW  memory read data, RD_LAT cycles after address

## Operation
- Winner selection each cycle:
  - Neither Req: no grant.
  - Single Req: that port wins.
  - Both Req: port 0 wins unless WaitCnt == MAX_WAIT, in which case port 1 wins.
- Winner drives Mem_Addr, Mem_Wr and Mem_WData; Mem_En = 1; its Gnt = 1.
- With no winner, Mem_En, Mem_Wr, Mem_Addr and Mem_WData are all 0.
- WaitCnt register, width $clog2(MAX_WAIT+1):
  - Increments when Req1 && Gnt0, saturating at MAX_WAIT.
  - Clears when Gnt1 or !Req1.
- Read tracking: a granted read pushes {valid=1, port} into an RD_LAT-deep pipeline; writes and idle cycles push valid=0.
  - At the pipeline output, RValidN = valid && port==N.
- Requester contract:
  - Addr/Wr/WData are stable while Req is high and Gnt is low.
  - Req may stay high after Gnt to request back-to-back accesses.
  - The arbiter never drops a held request.
- Reset (Rst=1 at an edge):
  - WaitCnt ← 0; read pipeline flushed.
  - While Rst is high, Gnt0/Gnt1, Mem_En and Mem_Wr are forced 0.
  - Reads in flight at reset never produce RValid.
- Reset values: Gnt0 = Gnt1 = 0, Mem_En = Mem_Wr = 0, Mem_Addr = 0, Mem_WData = 0, RValid0 = RValid1 = 0, WaitCnt = 0.

## Timing
- Grant latency 0: Req sampled high in cycle N gives Gnt and the memory access in cycle N.
- Read data: RValid and RData in cycle N+RD_LAT, one cycle wide.
- Writes take effect at the cycle-N edge; no response pulse.
- Throughput: 1 access per cycle total.
- Worst-case host wait under a continuous CPU request: MAX_WAIT cycles, granted in cycle MAX_WAIT+1.
- Back-to-back reads from alternating ports return in issue order, one per cycle.
- Rst deasserting in cycle N: arbitration is live in cycle N+1.

## Structure
- Package dmem_arb_pkg:
  - typedef port_id_t (1 bit; PORT_CPU=0, PORT_HOST=1)
  - typedef rd_tag_t struct {valid, port_id_t port}
  - localparam defaults for AW and DW
- Sub-module rd_tag_pipe: RD_LAT-deep shift register of rd_tag_t with synchronous flush; the top holds the arbitration logic and WaitCnt.

## Test plan
- Reset: Rst=1 with Req0=Req1=1 → Gnt0=Gnt1=0, Mem_En=0. After Rst drops, the next cycle gives Gnt0=1.
- CPU read only, RD_LAT=1: Req0=1, Wr0=0, Addr0=0x12, memory returns 0xBEEF → Gnt0 in cycle N; RValid0=1 and RData=0xBEEF in N+1; RValid1=0.
- Starvation, MAX_WAIT=4: Req0 and Req1 held continuously → Gnt0 in cycles 1–4, Gnt1 in cycle 5, WaitCnt=0 after cycle 5, then Gnt0 in cycles 6–9.
- Alternating reads, RD_LAT=2: host read to 0x05 (data 0x1111) in cycle N, CPU read to 0x06 (data 0x2222) in N+1 → RValid1 with 0x1111 in N+2, RValid0 with 0x2222 in N+3.
- Write then read: host writes 0xA5A5 to 0x80 in cycle N, CPU reads 0x80 in N+1 → Mem_Wr=1 only in N; RValid0 in N+1+RD_LAT with RData=0xA5A5.
- Reset mid-read, RD_LAT=3: CPU read granted in cycle N, Rst=1 at the N+1 edge → no RValid0 in cycles N+1..N+4.
